// File: rtl/bs_sequencer.sv
// Microcoded sequencer for the bit-serial interpolation datapath y <- y*d + x*(1-d).
// Holds pc, multiply phase and serial bit counter; decodes the fixed microcode ROM into datapath strobes.
module bs_sequencer #(
  parameter int WIDTH = 8,
  parameter int PC_W  = 3,
  // Entry i occupies bits [3*i+2:3*i]; one octal digit per entry, entry 0 rightmost.
  parameter logic [3*(2**PC_W)-1:0] ROM = 24'o64312170
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_mul_done,
  output logic [PC_W-1:0]          o_pc,
  output logic [2:0]               o_op,
  output logic                     o_con_pcincr,
  output logic                     o_load,
  output logic                     o_mul_go,
  output logic                     o_mul_sel,
  output logic                     o_add_en,
  output logic [$clog2(WIDTH)-1:0] o_bit_idx,
  output logic                     o_busy,
  output logic                     o_result_valid,
  output logic                     o_err
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_WAITON  = 3'b000,
    OP_STALL   = 3'b001,
    OP_MULYD   = 3'b010,
    OP_MULX1D  = 3'b011,
    OP_ADD     = 3'b100,
    OP_RSV     = 3'b101,
    OP_WAITOFF = 3'b110,
    OP_LOAD    = 3'b111
  } op_e;

  typedef enum logic {
    PH_ISSUE = 1'b0,
    PH_WAIT  = 1'b1
  } phase_e;

  logic [PC_W-1:0]  pc;
  phase_e           phase;
  logic [CNT_W-1:0] cnt;
  logic             err;
  op_e              op;
  logic             pc_incr;
  logic             is_mul;

  assign op     = op_e'(ROM[3*int'(pc) +: 3]);
  assign is_mul = (op == OP_MULYD) || (op == OP_MULX1D);

  always_comb begin
    // NOTE: default first so every path assigns pc_incr; otherwise a latch is inferred.
    pc_incr = 1'b0;
    case (op)
      OP_WAITON:            pc_incr = i_start;
      OP_LOAD,
      OP_STALL,
      OP_RSV:               pc_incr = 1'b1;
      OP_MULYD, OP_MULX1D:  pc_incr = (phase == PH_WAIT) && i_mul_done;
      OP_ADD:               pc_incr = (cnt == CNT_W'(WIDTH - 1));
      OP_WAITOFF:           pc_incr = !i_start;
      default:              pc_incr = 1'b0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc    <= '0;
      phase <= PH_ISSUE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      if (pc_incr) pc <= pc + PC_W'(1);
      case (op)
        OP_MULYD, OP_MULX1D: begin
          // A done pulse seen during ISSUE belongs to nothing we launched.
          if (phase == PH_ISSUE)  phase <= PH_WAIT;
          else if (i_mul_done)    phase <= PH_ISSUE;
        end
        OP_ADD:  cnt <= pc_incr ? '0 : cnt + CNT_W'(1);
        OP_RSV:  err <= 1'b1;
        default: ;
      endcase
    end
  end

  assign o_pc           = pc;
  assign o_op           = op;
  assign o_con_pcincr   = pc_incr;
  assign o_load         = (op == OP_LOAD);
  // Launch and shift strobes are gated by reset so they drop in the reset cycle itself.
  assign o_mul_go       = is_mul && (phase == PH_ISSUE) && !i_rst;
  assign o_mul_sel      = (op == OP_MULX1D);
  assign o_add_en       = (op == OP_ADD) && !i_rst;
  assign o_bit_idx      = cnt;
  assign o_busy         = (pc != '0);
  assign o_result_valid = (op == OP_WAITOFF);
  assign o_err          = err;

endmodule

// File: tb/tb_bs_sequencer.sv
// Directed bench for bs_sequencer: scoreboard of expected per-cycle pc/strobes, plus a
// second instance whose ROM carries the reserved opcode at entry 4.
module tb_bs_sequencer;

  logic       clk = 1'b0;
  logic       i_rst, i_start, i_mul_done;
  logic [2:0] o_pc, o_op, o_bit_idx;
  logic       o_con_pcincr, o_load, o_mul_go, o_mul_sel, o_add_en, o_busy, o_result_valid, o_err;
  logic [2:0] r_pc, r_op, r_bit_idx;
  logic       r_con_pcincr, r_load, r_mul_go, r_mul_sel, r_add_en, r_busy, r_result_valid, r_err;

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;

  typedef struct {
    logic [2:0] pc;
    logic       rv;
    logic       rerr;
  } exp_t;

  exp_t       exp_q[$];
  logic       sel_q[$];
  logic [2:0] bit_q[$];

  logic [2:0] rom_tab [8] = '{3'd0, 3'd7, 3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd6};
  logic [2:0] rsv_tab [8] = '{3'd0, 3'd7, 3'd1, 3'd2, 3'd5, 3'd3, 3'd4, 3'd6};

  always #5 clk = ~clk;

  bs_sequencer dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_mul_done(i_mul_done),
    .o_pc(o_pc), .o_op(o_op), .o_con_pcincr(o_con_pcincr), .o_load(o_load),
    .o_mul_go(o_mul_go), .o_mul_sel(o_mul_sel), .o_add_en(o_add_en),
    .o_bit_idx(o_bit_idx), .o_busy(o_busy), .o_result_valid(o_result_valid), .o_err(o_err)
  );

  bs_sequencer #(.ROM(24'o64352170)) dut_rsv (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_mul_done(i_mul_done),
    .o_pc(r_pc), .o_op(r_op), .o_con_pcincr(r_con_pcincr), .o_load(r_load),
    .o_mul_go(r_mul_go), .o_mul_sel(r_mul_sel), .o_add_en(r_add_en),
    .o_bit_idx(r_bit_idx), .o_busy(r_busy), .o_result_valid(r_result_valid), .o_err(r_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Multiplier model: done is returned in the 8th cycle after the go cycle.
  task automatic resp_tick();
    i_mul_done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) i_mul_done = 1'b1;
    end
    if (o_mul_go) resp_cnt = 8;
  endtask

  task automatic push_pc(input logic [2:0] pc, input int n, input logic rerr_pre);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = pc;
      e.rv   = (pc == 3'd7);
      e.rerr = rerr_pre || (pc >= 3'd5);
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge with pc=0; the next posedge samples i_start=1.
  task automatic run_program(input string name, input logic rerr_pre);
    exp_t e;
    int   loads = 0;
    int   gos   = 0;
    exp_q.delete();
    sel_q.delete();
    bit_q.delete();
    push_pc(3'd1, 1, rerr_pre);
    push_pc(3'd2, 1, rerr_pre);
    push_pc(3'd3, 9, rerr_pre);
    push_pc(3'd4, 1, rerr_pre);
    push_pc(3'd5, 9, rerr_pre);
    push_pc(3'd6, 8, rerr_pre);
    push_pc(3'd7, 1, rerr_pre);
    sel_q.push_back(1'b0);
    sel_q.push_back(1'b1);
    for (int b = 0; b < 8; b++) bit_q.push_back(3'(b));
    resp_cnt = 0;
    i_start  = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check({name, "_pc"}, o_pc, e.pc);
      check({name, "_op"}, o_op, rom_tab[e.pc]);
      check({name, "_busy"}, o_busy, (e.pc != 3'd0));
      check({name, "_rvalid"}, o_result_valid, e.rv);
      check({name, "_err"}, o_err, 1'b0);
      check({name, "_load"}, o_load, (e.pc == 3'd1));
      check({name, "_add_en"}, o_add_en, (e.pc == 3'd6));
      check({name, "_excl"}, ($countones({o_load, o_mul_go, o_add_en}) <= 1), 1'b1);
      if (e.pc == 3'd3 || e.pc == 3'd5) check({name, "_sel_hold"}, o_mul_sel, (e.pc == 3'd5));
      check({name, "_rsv_pc"}, r_pc, e.pc);
      check({name, "_rsv_op"}, r_op, rsv_tab[e.pc]);
      check({name, "_rsv_err"}, r_err, e.rerr);
      if (o_load) loads++;
      if (o_mul_go) begin
        gos++;
        if (sel_q.size() > 0) check({name, "_go_sel"}, o_mul_sel, sel_q.pop_front());
        else check({name, "_extra_go"}, o_mul_go, 1'b0);
      end
      if (o_add_en) begin
        if (bit_q.size() > 0) check({name, "_bit_idx"}, o_bit_idx, bit_q.pop_front());
        else check({name, "_extra_add"}, o_add_en, 1'b0);
      end
      resp_tick();
    end
    i_mul_done = 1'b0;
    check({name, "_load_count"}, loads, 1);
    check({name, "_go_count"}, gos, 2);
    check({name, "_bits_left"}, bit_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int   go_seen;

    // Reset state
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_mul_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", o_pc, 3'd0);
    check("rst_op", o_op, 3'd0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_rvalid", o_result_valid, 1'b0);
    check("rst_strobes", {o_load, o_mul_go, o_add_en}, 3'b000);
    check("rst_err", o_err, 1'b0);
    check("rst_rsv_err", r_err, 1'b0);
    i_rst = 1'b0;
    @(negedge clk);
    check("idle_pc", o_pc, 3'd0);
    check("idle_pcincr", o_con_pcincr, 1'b0);

    // First full run; the reserved-ROM twin follows the same pc trace
    run_program("run1", 1'b0);

    // i_start held high at WAITOFF must not restart
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_pc", o_pc, 3'd7);
      check("hold_rvalid", o_result_valid, 1'b1);
    end
    i_start = 1'b0;
    @(negedge clk);
    check("wrap_pc", o_pc, 3'd0);
    check("wrap_busy", o_busy, 1'b0);
    check("wrap_rsv_err", r_err, 1'b1);

    // Second run after a single low cycle; err on the twin stays sticky
    run_program("run2", 1'b1);
    i_start = 1'b0;
    @(negedge clk);
    check("end2_pc", o_pc, 3'd0);

    // Reset mid-ADD at cnt=3
    i_start  = 1'b1;
    resp_cnt = 0;
    found    = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (o_add_en && o_bit_idx == 3'd3) found = 1'b1;
      else resp_tick();
    end
    check("reach_add3", found, 1'b1);
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_mul_done = 1'b0;
    #1;
    check("rst_add_drop", o_add_en, 1'b0);
    @(negedge clk);
    check("midrst_pc", o_pc, 3'd0);
    check("midrst_add_en", o_add_en, 1'b0);
    check("midrst_bit_idx", o_bit_idx, 3'd0);
    check("midrst_err", o_err, 1'b0);
    check("midrst_rsv_err", r_err, 1'b0);
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    check("postrst_pc", o_pc, 3'd0);

    // Multiplier stall with no done for 50 cycles
    i_start = 1'b1;
    @(negedge clk);
    check("st_pc1", o_pc, 3'd1);
    @(negedge clk);
    check("st_pc2", o_pc, 3'd2);
    @(negedge clk);
    check("st_pc3", o_pc, 3'd3);
    check("st_go_first", o_mul_go, 1'b1);
    check("st_sel0", o_mul_sel, 1'b0);
    go_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("st_hold_pc", o_pc, 3'd3);
      if (o_mul_go) go_seen++;
    end
    check("st_go_extra", go_seen, 0);
    i_mul_done = 1'b1;
    @(negedge clk);
    i_mul_done = 1'b0;
    check("st_adv_pc", o_pc, 3'd4);

    // Spurious done in ISSUE is ignored; the pulse 4 cycles later advances
    @(negedge clk);
    check("sp_pc5", o_pc, 3'd5);
    check("sp_go", o_mul_go, 1'b1);
    check("sp_sel1", o_mul_sel, 1'b1);
    i_mul_done = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      i_mul_done = (i == 4);
      check("sp_hold_pc", o_pc, 3'd5);
      check("sp_no_go", o_mul_go, 1'b0);
      check("sp_sel_held", o_mul_sel, 1'b1);
    end
    @(negedge clk);
    i_mul_done = 1'b0;
    check("sp_adv_pc", o_pc, 3'd6);
    check("sp_bit0", o_bit_idx, 3'd0);
    repeat (7) @(negedge clk);
    check("sp_bit7", o_bit_idx, 3'd7);
    @(negedge clk);
    check("sp_end_pc", o_pc, 3'd7);
    check("sp_end_rvalid", o_result_valid, 1'b1);
    check("sp_end_add_en", o_add_en, 1'b0);
    i_start = 1'b0;
    @(negedge clk);
    check("sp_wrap_pc", o_pc, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
